fetch_pc_unit: RTL and testbench

- Program-counter and fetch-sequencing stage that sits directly upstream of the instruction memory in the single-cycle RISC-V datapath.
- Holds the architectural PC, drives the word `Address` into instruction memory, and samples the returned `Instruction`.
- Selects the next PC from sequential, branch and jalr sources, and reports execution validity, halt and fault status to the control/decode stage.

---
 rtl/fetch_pc_if.sv | 31 +++
 rtl/fetch_pc_unit.sv | 96 +++++++++
 tb/tb_fetch_pc_unit.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/fetch_pc_if.sv
// Fetch-stage bus between control/decode, instruction memory and the PC unit.
// The unit owns Address/PC/status (slave side). The control side drives the redirect inputs and Instruction.
interface fetch_pc_if #(
    parameter int REGSIZE = 32,
    parameter int BITSIZE = 32
);
    logic               Stall;
    logic               BranchTaken;
    logic               JumpReg;
    logic [BITSIZE-1:0] ImmOffset;
    logic [BITSIZE-1:0] JumpBase;
    logic [BITSIZE-1:0] Instruction;
    logic [REGSIZE-1:0] Address;
    logic [BITSIZE-1:0] PC;
    logic [BITSIZE-1:0] PCPlus4;
    logic               Valid;
    logic               Halted;
    logic               Fault;
    logic [BITSIZE-1:0] FaultPC;
    logic [BITSIZE-1:0] InstrCount;

    modport master (
        output Stall, BranchTaken, JumpReg, ImmOffset, JumpBase, Instruction,
        input  Address, PC, PCPlus4, Valid, Halted, Fault, FaultPC, InstrCount
    );

    modport slave (
        input  Stall, BranchTaken, JumpReg, ImmOffset, JumpBase, Instruction,
        output Address, PC, PCPlus4, Valid, Halted, Fault, FaultPC, InstrCount
    );
endinterface

// File: rtl/fetch_pc_unit.sv
// PC register and fetch sequencer; Address follows PC in the same cycle and Instruction is used combinationally.
// Stall holds the PC with no retire. HALT and FAULT are terminal until rst.
module fetch_pc_unit #(
    parameter int                 REGSIZE   = 32,
    parameter int                 BITSIZE   = 32,
    parameter int                 MEM_WORDS = 32,
    parameter logic [BITSIZE-1:0] RESET_PC  = 32'h0000_0004,
    parameter logic [BITSIZE-1:0] HALT_WORD = 32'h0000_0073
) (
    input  logic       clk,
    input  logic       rst,
    fetch_pc_if.slave  bus
);
    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        HALT  = 2'd2,
        FAULT = 2'd3
    } state_t;

    localparam logic [BITSIZE-1:0] MEM_LIMIT = BITSIZE'(MEM_WORDS);

    state_t             state_q, state_d;
    logic [BITSIZE-1:0] pc_q, pc_d;
    logic [BITSIZE-1:0] fault_pc_q, fault_pc_d;
    logic [BITSIZE-1:0] instr_count_q, instr_count_d;
    logic [BITSIZE-1:0] next_pc;
    logic               is_halt;
    logic               target_bad;
    logic               valid;

    // jalr beats a taken branch; jalr target has bit 0 forced low
    always_comb begin
        next_pc = pc_q + BITSIZE'(4);
        if (bus.JumpReg) begin
            next_pc = (bus.JumpBase + bus.ImmOffset) & ~BITSIZE'(1);
        end else if (bus.BranchTaken) begin
            next_pc = pc_q + bus.ImmOffset;
        end
    end

    assign is_halt    = (bus.Instruction == HALT_WORD);
    assign target_bad = (next_pc[1:0] != 2'b00) || ((next_pc >> 2) >= MEM_LIMIT);
    assign valid      = (state_q == RUN) && !bus.Stall && !is_halt;

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        fault_pc_d    = fault_pc_q;
        instr_count_d = instr_count_q;

        if (valid && (instr_count_q != '1)) begin
            instr_count_d = instr_count_q + BITSIZE'(1);
        end

        case (state_q)
            BOOT: state_d = RUN;
            RUN: begin
                if (is_halt) begin
                    state_d = HALT;
                end else if (!bus.Stall) begin
                    if (target_bad) begin
                        state_d    = FAULT;
                        fault_pc_d = next_pc;
                    end else begin
                        pc_d = next_pc;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= BOOT;
            pc_q          <= RESET_PC;
            fault_pc_q    <= '0;
            instr_count_q <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            fault_pc_q    <= fault_pc_d;
            instr_count_q <= instr_count_d;
        end
    end

    assign bus.Address    = REGSIZE'(pc_q >> 2);
    assign bus.PC         = pc_q;
    assign bus.PCPlus4    = pc_q + BITSIZE'(4);
    assign bus.Valid      = valid;
    assign bus.Halted     = (state_q == HALT);
    assign bus.Fault      = (state_q == FAULT);
    assign bus.FaultPC    = fault_pc_q;
    assign bus.InstrCount = instr_count_q;
endmodule

// File: tb/tb_fetch_pc_unit.sv
// Scoreboard bench for fetch_pc_unit: directed scenarios, then randomized episodes against a reference model.
module tb_fetch_pc_unit;
    localparam int          MEM_WORDS = 32;
    localparam logic [31:0] RESET_PC  = 32'h4;
    localparam logic [31:0] HALT_WORD = 32'h73;
    localparam logic [31:0] NOP       = 32'h13;
    localparam int S_BOOT = 0, S_RUN = 1, S_HALT = 2, S_FAULT = 3;

    typedef struct {
        logic [31:0] pc, addr, pcp4, fpc, cnt;
        logic        valid, halted, fault;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fetch_pc_if #(.REGSIZE(32), .BITSIZE(32)) bus ();
    fetch_pc_unit #(.REGSIZE(32), .BITSIZE(32), .MEM_WORDS(MEM_WORDS),
                    .RESET_PC(RESET_PC), .HALT_WORD(HALT_WORD))
        dut (.clk(clk), .rst(rst), .bus(bus));

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    event mon_kick;

    int          m_st;
    logic [31:0] m_pc, m_fpc, m_cnt;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    always begin
        @(negedge clk or mon_kick);
        while (exp_q.size() != 0) begin
            exp_t e;
            e = exp_q.pop_front();
            cmp("pc",      bus.PC,         e.pc);
            cmp("address", bus.Address,    e.addr);
            cmp("pcplus4", bus.PCPlus4,    e.pcp4);
            cmp("valid",   32'(bus.Valid),  32'(e.valid));
            cmp("halted",  32'(bus.Halted), 32'(e.halted));
            cmp("fault",   32'(bus.Fault),  32'(e.fault));
            cmp("faultpc", bus.FaultPC,    e.fpc);
            cmp("count",   bus.InstrCount, e.cnt);
        end
    end

    task automatic m_reset();
        m_st = S_BOOT; m_pc = RESET_PC; m_fpc = 0; m_cnt = 0;
    endtask

    function automatic exp_t m_outputs(input logic s, input logic [31:0] ins);
        exp_t e;
        e.pc     = m_pc;
        e.addr   = m_pc / 4;
        e.pcp4   = m_pc + 4;
        e.fpc    = m_fpc;
        e.cnt    = m_cnt;
        e.valid  = (m_st == S_RUN) && !s && (ins != HALT_WORD);
        e.halted = (m_st == S_HALT);
        e.fault  = (m_st == S_FAULT);
        return e;
    endfunction

    // Architectural effect of one clock edge, straight from the fetch rules
    task automatic m_step(input logic s, input logic b, input logic j,
                          input logic [31:0] imm, input logic [31:0] base, input logic [31:0] ins);
        logic [31:0] tgt;
        if (m_st == S_RUN && !s && ins != HALT_WORD && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
        if (m_st == S_BOOT) m_st = S_RUN;
        else if (m_st == S_RUN) begin
            if (ins == HALT_WORD) m_st = S_HALT;
            else if (!s) begin
                if (j)      tgt = (base + imm) & 32'hFFFF_FFFE;
                else if (b) tgt = m_pc + imm;
                else        tgt = m_pc + 4;
                if ((tgt % 4) != 0 || (tgt / 4) >= MEM_WORDS) begin
                    m_st  = S_FAULT;
                    m_fpc = tgt;
                end else m_pc = tgt;
            end
        end
    endtask

    task automatic cyc(input logic s, input logic b, input logic j,
                       input logic [31:0] imm, input logic [31:0] base, input logic [31:0] ins);
        bus.Stall = s; bus.BranchTaken = b; bus.JumpReg = j;
        bus.ImmOffset = imm; bus.JumpBase = base; bus.Instruction = ins;
        exp_q.push_back(m_outputs(s, ins));
        if (!rst) m_step(s, b, j, imm, base, ins);
        @(posedge clk); #1;
    endtask

    task automatic nop(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, NOP);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        m_reset();
        nop(1);
        rst = 1'b0;
    endtask

    task automatic mid_reset();
        @(negedge clk); #2;
        rst = 1'b1;
        m_reset();
        #1;
        exp_q.push_back(m_outputs(1'b0, NOP));
        -> mon_kick;
        @(posedge clk); #1;
        nop(1);
        rst = 1'b0;
    endtask

    initial begin
        logic s, b, j;
        logic [31:0] imm, base, ins, tgt;
        bus.Stall = 0; bus.BranchTaken = 0; bus.JumpReg = 0;
        bus.ImmOffset = 0; bus.JumpBase = 0; bus.Instruction = NOP;
        m_reset();
        @(posedge clk); #1;
        do_reset();

        // free run, stall, branch, jalr-over-branch, boundary targets
        nop(3);
        cmp("tp_pc_after_3", bus.PC, 32'd12);
        cmp("tp_count_after_3", bus.InstrCount, 32'd2);
        cyc(1, 0, 0, 0, 0, NOP);
        cyc(1, 0, 0, 0, 0, NOP);
        cmp("tp_stall_hold", bus.PC, 32'd12);
        nop(1);
        cyc(0, 1, 0, 32'hFFFF_FFF8, 0, NOP);
        cmp("tp_branch_back", bus.PC, 32'd8);
        cyc(0, 1, 1, 32'h1, 32'h40, NOP);
        cmp("tp_jalr_wins", bus.PC, 32'h40);
        cyc(0, 0, 1, 32'h7C, 32'h0, NOP);
        cyc(0, 0, 1, 32'h0, 32'h0, NOP);
        cmp("tp_word0_legal", bus.PC, 32'h0);
        cyc(0, 1, 0, 32'h80, 0, NOP);
        cmp("tp_word32_fault", bus.FaultPC, 32'h80);
        cyc(0, 1, 1, 32'h8, 32'h8, NOP);
        cyc(0, 0, 0, 0, 0, HALT_WORD);

        // misaligned branch: masked by stall, then faults
        do_reset();
        nop(2);
        cyc(1, 1, 0, 32'h2, 0, NOP);
        cyc(0, 1, 0, 32'h2, 0, NOP);
        cmp("tp_misalign_faultpc", bus.FaultPC, 32'd10);
        cmp("tp_misalign_pc", bus.PC, 32'd8);

        // halt word under stall, then frozen against redirects
        do_reset();
        nop(5);
        cyc(1, 0, 0, 0, 0, HALT_WORD);
        cmp("tp_halted", 32'(bus.Halted), 32'd1);
        cyc(0, 1, 0, 32'h8, 0, NOP);
        cyc(0, 0, 1, 32'h8, 32'h10, NOP);
        cmp("tp_halt_frozen", bus.PC, 32'd20);

        // wrap past the top of the address space
        do_reset();
        nop(1);
        cyc(0, 1, 0, 32'hFFFF_FFF8, 0, NOP);
        cmp("tp_wrap_fault", bus.FaultPC, 32'hFFFF_FFFC);

        // asynchronous reset in RUN at PC=24, then normal resume
        do_reset();
        nop(6);
        cmp("tp_pc24", bus.PC, 32'd24);
        mid_reset();
        nop(4);
        cmp("tp_resume_pc", bus.PC, 32'd16);

        for (int ep = 0; ep < 30; ep++) begin
            do_reset();
            for (int c = 0; c < 40; c++) begin
                s = ($urandom_range(0, 4) == 0);
                j = ($urandom_range(0, 5) == 0);
                b = ($urandom_range(0, 3) == 0);
                ins = $urandom;
                if (ins == HALT_WORD || $urandom_range(0, 60) != 0) ins = (ins == HALT_WORD) ? NOP : ins;
                else ins = HALT_WORD;
                tgt = 32'($urandom_range(0, MEM_WORDS - 1)) * 4;
                case ($urandom_range(0, 9))
                    0: tgt = tgt + 32'($urandom_range(1, 3));
                    1: tgt = $urandom;
                    2: tgt = 32'(MEM_WORDS) * 4;
                    default: ;
                endcase
                base = $urandom;
                imm = j ? tgt - base : (b ? tgt - m_pc : $urandom);
                cyc(s, b, j, imm, base, ins);
            end
            if (ep % 7 == 3) begin
                mid_reset();
                nop(3);
            end
        end

        @(negedge clk); #1;
        cmp("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
